// File: rtl/float_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
// Holds the operand class enum, flag bit positions and IEEE field constructors.
package float_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic int bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Words are built wide and sliced to W by the user.
  function automatic logic [127:0] qnan_bits(input int e, input int m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i <= e; i++) r[m-1+i] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] inf_bits(input int e, input int m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < e; i++) r[m+i] = 1'b1;
    return r;
  endfunction

  function automatic fclass_e classify(
    input logic e_zero,
    input logic e_ones,
    input logic m_nz
  );
    fclass_e c;
    c = CLS_NORM;
    if (e_zero) c = CLS_ZERO;
    else if (e_ones) c = m_nz ? CLS_NAN : CLS_INF;
    return c;
  endfunction

endpackage

// File: rtl/float_mul_norm_round.sv
// Normalise, round-to-nearest-even and pack a raw significand product.
// Special operand classes override the arithmetic result by priority.
module float_mul_norm_round
  import float_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 23,
  parameter int W = E + M + 1
) (
  input  logic [2*M+1:0] i_prod,
  input  logic [E+1:0]   i_exp,
  input  logic           i_sign,
  input  logic [1:0]     i_ca,
  input  logic [1:0]     i_cb,
  output logic [W-1:0]   o_c,
  output logic [2:0]     o_flags
);

  localparam logic [127:0] QNAN_L = qnan_bits(E, M);
  localparam logic [127:0] INF_L  = inf_bits(E, M);
  localparam logic signed [E+1:0] EMAX = {2'b00, {E{1'b1}}};

  logic                w_hi;
  logic [M-1:0]        w_mant;
  logic                w_g;
  logic                w_s;
  logic                w_inc;
  logic [M:0]          w_rnd;
  logic signed [E+1:0] w_exp;
  logic                w_nan;
  logic                w_inf;
  logic                w_zero;

  assign w_hi   = i_prod[2*M+1];
  assign w_mant = w_hi ? i_prod[2*M:M+1] : i_prod[2*M-1:M];
  assign w_g    = w_hi ? i_prod[M] : i_prod[M-1];
  assign w_s    = w_hi ? |i_prod[M-1:0] : |i_prod[M-2:0];
  assign w_inc  = w_g & (w_s | w_mant[0]);
  assign w_rnd  = {1'b0, w_mant} + {{M{1'b0}}, w_inc};
  // Rounding carry-out leaves a zero fraction and bumps the exponent.
  assign w_exp  = i_exp + {{(E+1){1'b0}}, w_hi}
                + {{(E+1){1'b0}}, w_rnd[M]};

  assign w_nan  = (i_ca == CLS_NAN) | (i_cb == CLS_NAN)
                | ((i_ca == CLS_INF) & (i_cb == CLS_ZERO))
                | ((i_ca == CLS_ZERO) & (i_cb == CLS_INF));
  assign w_inf  = (i_ca == CLS_INF) | (i_cb == CLS_INF);
  assign w_zero = (i_ca == CLS_ZERO) | (i_cb == CLS_ZERO);

  always_comb begin
    o_c     = {i_sign, w_exp[E-1:0], w_rnd[M-1:0]};
    o_flags = '0;
    if (w_nan) begin
      o_c              = QNAN_L[W-1:0];
      o_flags[FLG_INV] = 1'b1;
    end else if (w_inf) begin
      o_c = {i_sign, INF_L[W-2:0]};
    end else if (w_zero) begin
      o_c = {i_sign, {(W-1){1'b0}}};
    end else if (w_exp >= EMAX) begin
      o_c              = {i_sign, INF_L[W-2:0]};
      o_flags[FLG_OVF] = 1'b1;
    end else if (w_exp <= 0) begin
      o_c              = {i_sign, {(W-1){1'b0}}};
      o_flags[FLG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage streaming IEEE-754 multiplier with valid/ready backpressure.
// Stages: unpack/classify, significand multiply, normalise/round/pack.
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 23,
  parameter int W = E + M + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic [2:0]   out_flags
);

  localparam logic [E+1:0] BIAS = (E+2)'(bias(E));

  logic         w_en;
  logic [E-1:0] w_ea, w_eb;
  logic [M-1:0] w_ma, w_mb;
  fclass_e      w_ca, w_cb;
  logic [W-1:0] w_c;
  logic [2:0]   w_flags;

  logic         r1_v, r1_sign;
  fclass_e      r1_ca, r1_cb;
  logic [M:0]   r1_sa, r1_sb;
  logic [E+1:0] r1_exp;

  logic           r2_v, r2_sign;
  fclass_e        r2_ca, r2_cb;
  logic [2*M+1:0] r2_prod;
  logic [E+1:0]   r2_exp;

  logic         r_out_v;
  logic [W-1:0] r_out_c;
  logic [2:0]   r_out_flags;

  assign w_en = !r_out_v | out_ready;
  assign w_ea = in_a[W-2:M];
  assign w_eb = in_b[W-2:M];
  assign w_ma = in_a[M-1:0];
  assign w_mb = in_b[M-1:0];
  assign w_ca = classify(w_ea == '0, &w_ea, |w_ma);
  assign w_cb = classify(w_eb == '0, &w_eb, |w_mb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v    <= 1'b0;
      r1_sign <= 1'b0;
      r1_ca   <= CLS_ZERO;
      r1_cb   <= CLS_ZERO;
      r1_sa   <= '0;
      r1_sb   <= '0;
      r1_exp  <= '0;
    end else if (w_en) begin
      r1_v    <= in_valid;
      r1_sign <= in_a[W-1] ^ in_b[W-1];
      r1_ca   <= w_ca;
      r1_cb   <= w_cb;
      r1_sa   <= {1'b1, w_ma};
      r1_sb   <= {1'b1, w_mb};
      r1_exp  <= {2'b00, w_ea} + {2'b00, w_eb} - BIAS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_sign <= 1'b0;
      r2_ca   <= CLS_ZERO;
      r2_cb   <= CLS_ZERO;
      r2_prod <= '0;
      r2_exp  <= '0;
    end else if (w_en) begin
      r2_v    <= r1_v;
      r2_sign <= r1_sign;
      r2_ca   <= r1_ca;
      r2_cb   <= r1_cb;
      r2_prod <= {{(M+1){1'b0}}, r1_sa} * {{(M+1){1'b0}}, r1_sb};
      r2_exp  <= r1_exp;
    end
  end

  float_mul_norm_round #(
    .E(E),
    .M(M),
    .W(W)
  ) u_norm_round (
    .i_prod  (r2_prod),
    .i_exp   (r2_exp),
    .i_sign  (r2_sign),
    .i_ca    (r2_ca),
    .i_cb    (r2_cb),
    .o_c     (w_c),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v     <= 1'b0;
      r_out_c     <= '0;
      r_out_flags <= '0;
    end else if (w_en) begin
      r_out_v     <= r2_v;
      r_out_c     <= w_c;
      r_out_flags <= w_flags;
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_v;
  assign out_c     = r_out_c;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed bench for float_mul_pipe: single ops, backpressure stream,
// and reset while results are in flight.
module tb_float_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

  float_mul_pipe #(
    .E(8),
    .M(23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ec,
                         input logic [2:0] ef);
    int n;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n + 1), 32'd3);
    check({tag, "_c"}, out_c, ec);
    check({tag, "_f"}, 32'(out_flags), 32'(ef));
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] vc [8];
  logic [2:0]  vf [8];
  int          tx, rx;
  logic        stalled_prev, saw_stall;
  logic [31:0] held_c;
  logic [2:0]  held_f;

  initial begin
    va[0] = 32'h40000000; vb[0] = 32'h40400000; vc[0] = 32'h40C00000; vf[0] = 3'b000;
    va[1] = 32'h3F800800; vb[1] = 32'h3F800800; vc[1] = 32'h3F801000; vf[1] = 3'b000;
    va[2] = 32'h3F800001; vb[2] = 32'h3F800001; vc[2] = 32'h3F800002; vf[2] = 3'b000;
    va[3] = 32'h7F000000; vb[3] = 32'h40000000; vc[3] = 32'h7F800000; vf[3] = 3'b010;
    va[4] = 32'h00800000; vb[4] = 32'h3F000000; vc[4] = 32'h00000000; vf[4] = 3'b001;
    va[5] = 32'h7F800000; vb[5] = 32'h00000000; vc[5] = 32'h7FC00000; vf[5] = 3'b100;
    va[6] = 32'hFF800000; vb[6] = 32'h40000000; vc[6] = 32'hFF800000; vf[6] = 3'b000;
    va[7] = 32'h80000000; vb[7] = 32'h3F800000; vc[7] = 32'h80000000; vf[7] = 3'b000;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_c", out_c, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    run_one("mul2x3", va[0], vb[0], vc[0], vf[0]);
    run_one("tie_even", va[1], vb[1], vc[1], vf[1]);
    run_one("ulp", va[2], vb[2], vc[2], vf[2]);
    run_one("ovf", va[3], vb[3], vc[3], vf[3]);
    run_one("unf", va[4], vb[4], vc[4], vf[4]);
    run_one("inf_x_0", va[5], vb[5], vc[5], vf[5]);
    run_one("neg_inf", va[6], vb[6], vc[6], vf[6]);
    run_one("neg_zero", va[7], vb[7], vc[7], vf[7]);
    repeat (3) @(posedge clk);

    // Stream with downstream stalled for cycles 4..9.
    tx = 0;
    rx = 0;
    stalled_prev = 1'b0;
    saw_stall = 1'b0;
    held_c = '0;
    held_f = '0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      @(negedge clk);
      if (stalled_prev) begin
        check("stall_v", 32'(out_valid), 32'd1);
        check("stall_c", out_c, held_c);
        check("stall_f", 32'(out_flags), 32'(held_f));
      end
      out_ready = !(cyc >= 4 && cyc <= 9);
      in_valid  = (tx < 8);
      if (tx < 8) begin
        in_a = va[tx];
        in_b = vb[tx];
      end
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("strm_c%0d", rx), out_c, vc[rx]);
        check($sformatf("strm_f%0d", rx), 32'(out_flags), 32'(vf[rx]));
        rx++;
      end
      stalled_prev = out_valid && !out_ready;
      held_c = out_c;
      held_f = out_flags;
      if (in_valid && in_ready) tx++;
    end
    check("strm_rx", 32'(rx), 32'd8);
    check("strm_tx", 32'(tx), 32'd8);
    check("strm_stall_seen", 32'(saw_stall), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("strm_no_dup", 32'(out_valid), 32'd0);

    // Three operations in flight, then reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a     = va[i];
      in_b     = vb[i];
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_c", out_c, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_flush", 32'(out_valid), 32'd0);
    run_one("post_rst", va[0], vb[0], vc[0], vf[0]);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_mul_pipe.md
Name: float_mul_pipe

Overview:
Pipelined, parametrised IEEE-754 binary floating-point multiplier with valid/ready streaming handshake. It generalises the team's combinational single-precision multiplier in four ways: any exponent/mantissa width, round-to-nearest-even, full special-value handling, and exception flags. It sits in datapaths as a drop-in streaming stage with a fixed 3-cycle latency and full-throughput backpressure.

Parameters:
E, 8, exponent field width (>=3)
M, 23, stored mantissa width (>=2)
W, E+M+1, total word width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  pipeline can accept the operand pair
in_a  in  W  operand A {sign, exp, mant}
in_b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_c  out  W  product
out_flags  out  3  {invalid, overflow, underflow}

Behaviour:
- Reset (async assert, sync deassert inside clk domain): all stage valid bits = 0; out_valid = 0, out_c = 0, out_flags = 0; in_ready = 1 after reset.
- Three stages S1 -> S2 -> S3, each with a valid bit. Global advance en = !out_valid | out_ready. in_ready = en. Transfer on in_valid & in_ready.
- Latency: exactly 3 cycles from accepted input to out_valid when unstalled. Throughput: 1 per cycle. Stall holds all stage registers; bubbles are not collapsed.
- out_c/out_flags are stable while out_valid & !out_ready.
- S1: unpack; classify each operand as zero (exp=0, including subnormals: flush-to-zero), inf (exp=all-ones, mant=0), NaN (exp=all-ones, mant!=0), normal. Sign = sa^sb. Exponent sum signed, width E+2: ea+eb-BIAS, BIAS=2^(E-1)-1.
- S2: (M+1)x(M+1) unsigned product of significands with hidden 1, width 2M+2.
- S3 (sub-module): if product MSB set, shift right 1 and exp+1. Round to nearest, ties to even, using guard bit plus sticky OR of remaining bits. Mantissa carry-out on rounding increments the exponent again.
- Special-case priority:
  1. any NaN, or inf x zero: output canonical qNaN {0, all-ones, 1 followed by zeros}, invalid = 1.
  2. any inf: signed inf.
  3. any zero: signed zero.
  4. Final exp >= all-ones: signed inf, overflow = 1.
  5. Final exp <= 0: signed zero (flush-to-zero), underflow = 1.
- Only one flag is set per result; flags accompany their result.
- Reset mid-operation discards all in-flight data; no partial output.

Decomposition:
- float_pkg: BIAS(E) function, canonical-NaN/inf constructors, class enum {ZERO, NORM, INF, NAN}, flag bit indices.
- One sub-module float_mul_norm_round: combinational normalise + RNE round + overflow/underflow pack, taking the product, exponent and sign.

Test Plan:
- 0x40000000 x 0x40400000 (2.0 x 3.0) -> 0x40C00000, flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800800 x 0x3F800800 (tie case, 2^-24 extra) -> 0x3F801000 (rounded to even); 0x3F800001 x 0x3F800001 -> 0x3F800002.
- 0x7F000000 x 0x40000000 -> 0x7F800000, overflow = 1; 0x00800000 x 0x3F000000 -> 0x00000000, underflow = 1.
- 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid = 1; 0xFF800000 x 0x40000000 -> 0xFF800000; 0x80000000 x 0x3F800000 -> 0x80000000.
- Backpressure: stream 8 back-to-back pairs, hold out_ready = 0 for cycles 4-9 -> in_ready drops; all 8 results delivered in order with no loss or duplication; out_c stable while stalled.
- Assert rst_n low while 3 results are in flight -> out_valid = 0 immediately; after release, the first new input yields the correct result at latency 3.
